// File: rtl/aclk_time_counter.sv
// -----------------------------------------------------------------------------
// aclk_time_counter
//   Time-of-day keeper for the alarm clock. Holds 24-hour HH:MM as four BCD
//   digits that drive the LCD display stage. The time advances by one minute
//   per one_minute tick, and the controller can load a keyed-in time.
//   A load is checked for validity unless CHECK_LOAD is 0. The block flags a
//   23:59 -> 00:00 wrap and flags rejected loads.
//
// Ports
//   clock                    in   system clock; all state updates on rising edge
//   reset                    in   synchronous reset, active-low
//   one_minute               in   advance time by one minute this cycle
//   load_new_c               in   load new_current_time_* this cycle
//   new_current_time_*       in   4-bit BCD load digits (ms_hr, ls_hr, ms_min, ls_min)
//   current_time_*           out  4-bit BCD current time digits (registered)
//   day_rollover             out  one-cycle pulse when time wraps 23:59 -> 00:00
//   load_error               out  one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module aclk_time_counter #(
  parameter int INIT_MS_HR  = 0,
  parameter int INIT_LS_HR  = 0,
  parameter int INIT_MS_MIN = 0,
  parameter int INIT_LS_MIN = 0,
  parameter bit CHECK_LOAD  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       day_rollover,
  output logic       load_error
);

  // A load is valid only if every digit is in range and the hour is <= 23.
  // The concatenated BCD hour compares correctly as a hex number.
  function automatic logic load_is_valid(input logic [3:0] mh,
                                         input logic [3:0] lh,
                                         input logic [3:0] mm,
                                         input logic [3:0] lm);
    return (mh <= 4'd2) && (lh <= 4'd9) && (mm <= 4'd5) && (lm <= 4'd9) &&
           ({mh, lh} <= 8'h23);
  endfunction

  logic [3:0] ms_hr_s;
  logic [3:0] ls_hr_s;
  logic [3:0] ms_min_s;
  logic [3:0] ls_min_s;
  logic       rollover_s;
  logic       error_s;
  logic       load_ok_s;

  assign load_ok_s = !CHECK_LOAD ||
                     load_is_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                                   new_current_time_ms_min, new_current_time_ls_min);

  // Next-state selection: load beats tick, and a tick coincident with a load is dropped.
  always_comb begin
    ms_hr_s    = current_time_ms_hr;
    ls_hr_s    = current_time_ls_hr;
    ms_min_s   = current_time_ms_min;
    ls_min_s   = current_time_ls_min;
    rollover_s = 1'b0;
    error_s    = 1'b0;
    if (load_new_c) begin
      if (load_ok_s) begin
        ms_hr_s  = new_current_time_ms_hr;
        ls_hr_s  = new_current_time_ls_hr;
        ms_min_s = new_current_time_ms_min;
        ls_min_s = new_current_time_ls_min;
      end else begin
        error_s = 1'b1;
      end
    end else if (one_minute) begin
      // BCD ripple. The '>=' tests also pull out-of-range digits back into
      // range, so an unchecked load cannot wedge the counter.
      if (current_time_ls_min >= 4'd9) begin
        ls_min_s = 4'd0;
        if (current_time_ms_min >= 4'd5) begin
          ms_min_s = 4'd0;
          if (((current_time_ms_hr == 4'd2) && (current_time_ls_hr >= 4'd3)) ||
              (current_time_ms_hr > 4'd2)) begin
            ms_hr_s    = 4'd0;
            ls_hr_s    = 4'd0;
            rollover_s = 1'b1;
          end else if (current_time_ls_hr >= 4'd9) begin
            ls_hr_s = 4'd0;
            ms_hr_s = current_time_ms_hr + 4'd1;
          end else begin
            ls_hr_s = current_time_ls_hr + 4'd1;
          end
        end else begin
          ms_min_s = current_time_ms_min + 4'd1;
        end
      end else begin
        ls_min_s = current_time_ls_min + 4'd1;
      end
    end else begin
      error_s = 1'b0;
    end
  end

  // Output registers with synchronous active-low reset to the INIT time.
  always_ff @(posedge clock) begin
    if (!reset) begin
      current_time_ms_hr  <= 4'(INIT_MS_HR);
      current_time_ls_hr  <= 4'(INIT_LS_HR);
      current_time_ms_min <= 4'(INIT_MS_MIN);
      current_time_ls_min <= 4'(INIT_LS_MIN);
      day_rollover        <= 1'b0;
      load_error          <= 1'b0;
    end else begin
      current_time_ms_hr  <= ms_hr_s;
      current_time_ls_hr  <= ls_hr_s;
      current_time_ms_min <= ms_min_s;
      current_time_ls_min <= ls_min_s;
      day_rollover        <= rollover_s;
      load_error          <= error_s;
    end
  end

endmodule

// File: tb/tb_aclk_time_counter.sv
// -----------------------------------------------------------------------------
// tb_aclk_time_counter
//   Self-checking bench for aclk_time_counter with default parameters.
//   Directed scenario tasks compare against literal expected times. A
//   randomized task compares against a reference model that represents the
//   time as minutes since midnight.
// -----------------------------------------------------------------------------
module tb_aclk_time_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_minute;
  logic        load_new_c;
  logic [3:0]  n_ms_hr, n_ls_hr, n_ms_min, n_ls_min;
  logic [3:0]  c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
  logic        day_rollover;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  // Reference model state: minutes since midnight plus the two flags.
  int mins;
  bit m_dr;
  bit m_err;

  logic [17:0] dut_view;
  assign dut_view = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min, day_rollover, load_error};

  aclk_time_counter dut (
    .clock                   (clock),
    .reset                   (reset),
    .one_minute              (one_minute),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_ms_hr),
    .new_current_time_ls_hr  (n_ls_hr),
    .new_current_time_ms_min (n_ms_min),
    .new_current_time_ls_min (n_ls_min),
    .current_time_ms_hr      (c_ms_hr),
    .current_time_ls_hr      (c_ls_hr),
    .current_time_ms_min     (c_ms_min),
    .current_time_ls_min     (c_ls_min),
    .day_rollover            (day_rollover),
    .load_error              (load_error)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus, advance the clock, and update the model.
  // t holds the four BCD load digits as a 16-bit value such as 16'h1259.
  task automatic cycle(input logic r, input logic ld, input logic tk, input logic [15:0] t);
    int hr, mn;
    reset      = r;
    load_new_c = ld;
    one_minute = tk;
    {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = t;
    @(posedge clock);
    #1;
    hr = int'(t[15:12]) * 10 + int'(t[11:8]);
    mn = int'(t[7:4]) * 10 + int'(t[3:0]);
    if (!r) begin
      mins = 0; m_dr = 1'b0; m_err = 1'b0;
    end else if (ld) begin
      m_dr = 1'b0;
      if (t[11:8] <= 4'd9 && t[7:4] <= 4'd5 && t[3:0] <= 4'd9 && hr <= 23) begin
        mins = hr * 60 + mn; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (tk) begin
      mins = (mins + 1) % 1440; m_dr = (mins == 0); m_err = 1'b0;
    end else begin
      m_dr = 1'b0; m_err = 1'b0;
    end
  endtask

  function automatic logic [17:0] model_view();
    int hr, mn;
    hr = mins / 60;
    mn = mins % 60;
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), m_dr, m_err};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 16'h1234);
      total++;
      if (dut_view !== {16'h0000, 2'b00}) begin
        bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, dut_view, {16'h0000, 2'b00});
      end
    end
  endtask

  task automatic test_hour_carry();
    cycle(1'b1, 1'b1, 1'b0, 16'h1259);
    total++;
    if (dut_view !== {16'h1259, 2'b00}) begin
      bad++; $display("FAIL load_1259: got %h want %h", dut_view, {16'h1259, 2'b00});
    end
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h1300, 2'b00}) begin
      bad++; $display("FAIL carry_1300: got %h want %h", dut_view, {16'h1300, 2'b00});
    end
  endtask

  task automatic test_rollover();
    cycle(1'b1, 1'b1, 1'b0, 16'h2359);
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h0000, 2'b10}) begin
      bad++; $display("FAIL rollover: got %h want %h", dut_view, {16'h0000, 2'b10});
    end
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h0001, 2'b00}) begin
      bad++; $display("FAIL after_rollover: got %h want %h", dut_view, {16'h0001, 2'b00});
    end
    // Loading 00:00 is not a rollover.
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    total++;
    if (dut_view !== {16'h0000, 2'b00}) begin
      bad++; $display("FAIL load_0000: got %h want %h", dut_view, {16'h0000, 2'b00});
    end
  endtask

  task automatic test_invalid_load();
    cycle(1'b1, 1'b1, 1'b0, 16'h1000);
    cycle(1'b1, 1'b1, 1'b0, 16'h2400);
    total++;
    if (dut_view !== {16'h1000, 2'b01}) begin
      bad++; $display("FAIL reject_2400: got %h want %h", dut_view, {16'h1000, 2'b01});
    end
    cycle(1'b1, 1'b1, 1'b0, 16'h0960);
    total++;
    if (dut_view !== {16'h1000, 2'b01}) begin
      bad++; $display("FAIL reject_0960: got %h want %h", dut_view, {16'h1000, 2'b01});
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    total++;
    if (dut_view !== {16'h1000, 2'b00}) begin
      bad++; $display("FAIL error_clear: got %h want %h", dut_view, {16'h1000, 2'b00});
    end
  endtask

  task automatic test_load_priority();
    cycle(1'b1, 1'b1, 1'b1, 16'h0745);
    total++;
    if (dut_view !== {16'h0745, 2'b00}) begin
      bad++; $display("FAIL load_over_tick: got %h want %h", dut_view, {16'h0745, 2'b00});
    end
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'h0000);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    end
    total++;
    if (dut_view !== {16'h0845, 2'b00}) begin
      bad++; $display("FAIL sixty_ticks: got %h want %h", dut_view, {16'h0845, 2'b00});
    end
  endtask

  task automatic test_reset_midcount();
    cycle(1'b1, 1'b1, 1'b0, 16'h1908);
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h1909, 2'b00}) begin
      bad++; $display("FAIL count_1909: got %h want %h", dut_view, {16'h1909, 2'b00});
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h0000, 2'b00}) begin
      bad++; $display("FAIL midcount_reset: got %h want %h", dut_view, {16'h0000, 2'b00});
    end
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    total++;
    if (dut_view !== {16'h0001, 2'b00}) begin
      bad++; $display("FAIL resume: got %h want %h", dut_view, {16'h0001, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [15:0] t;
    int hr, mn;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        hr = int'($urandom_range(0, 23));
        mn = int'($urandom_range(0, 59));
        t  = {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10)};
      end else begin
        t = 16'($urandom);
      end
      // Occasionally start near midnight so rollovers appear often.
      if ($urandom_range(0, 99) == 0) begin
        t = 16'h2358;
      end
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 0), t);
      total++;
      if (dut_view !== model_view()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_view, model_view());
      end
    end
  endtask

  initial begin
    reset = 1'b0; load_new_c = 1'b0; one_minute = 1'b0;
    n_ms_hr = 4'd0; n_ls_hr = 4'd0; n_ms_min = 4'd0; n_ls_min = 4'd0;
    mins = 0; m_dr = 1'b0; m_err = 1'b0;
    test_reset();
    test_hour_carry();
    test_rollover();
    test_invalid_load();
    test_load_priority();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
